// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;
  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MUL_BUSY = 2'd2
  } hz_state_e;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic reg_match(logic [REG_AW-1:0] src, logic [REG_AW-1:0] dest);
    return (dest != REG_ZERO) && (src == dest);
  endfunction
endpackage

// File: rtl/raw_hazard_detect.sv
// Combinational RAW / load-use hazard detector for the ID stage.
module raw_hazard_detect
  import hazard_pkg::*;
(
  input  logic              forward_en,
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              two_src,
  input  logic [REG_AW-1:0] dest_exe,
  input  logic              wb_en_exe,
  input  logic              is_load_exe,
  input  logic [REG_AW-1:0] dest_mem,
  input  logic              wb_en_mem,
  output logic              hazard
);
  logic exe_hit;
  logic mem_hit;

  always_comb begin
    exe_hit = wb_en_exe && (reg_match(src1, dest_exe) || (two_src && reg_match(src2, dest_exe)));
    mem_hit = wb_en_mem && (reg_match(src1, dest_mem) || (two_src && reg_match(src2, dest_mem)));
    // With forwarding, only a load result is too late to bypass.
    if (forward_en) hazard = exe_hit && is_load_exe;
    else            hazard = exe_hit || mem_hit;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline, with memory-wait
// and multi-cycle multiply handling plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic [4:0]       src1_ID,
  input  logic [4:0]       src2_ID,
  input  logic             two_src_ID,
  input  logic [4:0]       dest_EXE,
  input  logic             WB_EN_EXE,
  input  logic             MEM_R_EN_EXE,
  input  logic [4:0]       dest_MEM,
  input  logic             WB_EN_MEM,
  input  logic             branch_taken_EXE,
  input  logic             mul_start_EXE,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  input  logic             perf_clr,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             bubble_EXE,
  output logic             flush_IF_ID,
  output logic             freeze,
  output logic             mul_done,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int unsigned MC_W      = $clog2(MUL_LAT) + 1;
  localparam int unsigned MUL_INIT  = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
  localparam logic        MUL_MULTI = (MUL_LAT > 1);

  hz_state_e        state_q, state_d;
  logic [MC_W-1:0]  mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic hazard;
  logic run_eval;
  logic frz, hz_stall, bub, flush, done;
  logic stall_if_int;

  raw_hazard_detect u_raw (
    .forward_en  (forward_en),
    .src1        (src1_ID),
    .src2        (src2_ID),
    .two_src     (two_src_ID),
    .dest_exe    (dest_EXE),
    .wb_en_exe   (WB_EN_EXE),
    .is_load_exe (MEM_R_EN_EXE),
    .dest_mem    (dest_MEM),
    .wb_en_mem   (WB_EN_MEM),
    .hazard      (hazard)
  );

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    frz       = 1'b0;
    hz_stall  = 1'b0;
    bub       = 1'b0;
    flush     = 1'b0;
    done      = 1'b0;
    run_eval  = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req_MEM && !mem_ready) begin
          frz     = 1'b1;
          state_d = MEM_WAIT;
        end else if (mul_start_EXE && MUL_MULTI) begin
          frz       = 1'b1;
          mul_cnt_d = MC_W'(MUL_INIT);
          state_d   = MUL_BUSY;
        end else begin
          done     = mul_start_EXE && !MUL_MULTI;
          run_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          frz = 1'b1;
        end else begin
          state_d  = RUN;
          run_eval = 1'b1;
        end
      end
      MUL_BUSY: begin
        if (mul_cnt_q != '0) begin
          frz       = 1'b1;
          mul_cnt_d = mul_cnt_q - MC_W'(1);
        end else begin
          done     = 1'b1;
          state_d  = RUN;
          run_eval = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // Exit cycles of the multi-cycle states still resolve branch/hazard.
    if (run_eval) begin
      if (branch_taken_EXE) begin
        flush = 1'b1;
        bub   = 1'b1;
      end else if (hazard) begin
        hz_stall = 1'b1;
        bub      = 1'b1;
      end
    end
  end

  always_comb begin
    stall_if_int = !rst && (frz || hz_stall);
    stall_IF     = stall_if_int;
    stall_ID     = stall_if_int;
    freeze       = !rst && frz;
    bubble_EXE   = !rst && bub;
    flush_IF_ID  = !rst && flush;
    mul_done     = !rst && done;
    stall_cycles = stall_cycles_q;
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (perf_clr)                                 stall_cycles_d = '0;
    else if (stall_if_int && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      mul_cnt_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mul_cnt_q      <= mul_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: constant vector table, directed
// multi-cycle sequences and randomized stimulus against a behavioural model.
module tb_pipeline_hazard_ctrl;
  typedef struct packed {
    logic       fwd;
    logic [4:0] s1;
    logic [4:0] s2;
    logic       two;
    logic [4:0] de;
    logic       wbe;
    logic       lde;
    logic [4:0] dm;
    logic       wbm;
    logic       br;
    logic       mul;
    logic       mreq;
    logic       mrdy;
    logic       clr;
  } in_t;

  typedef struct packed {
    logic sif;
    logic sid;
    logic bub;
    logic fl;
    logic frz;
    logic done;
  } out_t;

  typedef struct {
    string nm;
    in_t   v;
    out_t  o;
  } vec_t;

  localparam out_t O_NONE  = 6'b000000;
  localparam out_t O_FRZ   = 6'b110010;
  localparam out_t O_STALL = 6'b111000;
  localparam out_t O_FLUSH = 6'b001100;
  localparam out_t O_DONE  = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  logic forward_en, two_src_ID, WB_EN_EXE, MEM_R_EN_EXE, WB_EN_MEM;
  logic branch_taken_EXE, mul_start_EXE, mem_req_MEM, mem_ready, perf_clr;
  logic [4:0] src1_ID, src2_ID, dest_EXE, dest_MEM;

  logic sif4, sid4, bub4, fl4, frz4, done4;
  logic sif1, sid1, bub1, fl1, frz1, done1;
  logic [31:0] cnt4;
  logic [2:0]  cnt1;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  bit              m_memwait [2];
  int              m_mul_left[2];
  longint unsigned m_cnt     [2];
  int unsigned     lat       [2] = '{4, 1};
  longint unsigned cmax      [2] = '{64'hFFFF_FFFF, 64'd7};

  longint unsigned s_cnt4, s_cnt1;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .src1_ID(src1_ID), .src2_ID(src2_ID),
    .two_src_ID(two_src_ID), .dest_EXE(dest_EXE), .WB_EN_EXE(WB_EN_EXE),
    .MEM_R_EN_EXE(MEM_R_EN_EXE), .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM),
    .branch_taken_EXE(branch_taken_EXE), .mul_start_EXE(mul_start_EXE),
    .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .stall_IF(sif4), .stall_ID(sid4), .bubble_EXE(bub4), .flush_IF_ID(fl4),
    .freeze(frz4), .mul_done(done4), .stall_cycles(cnt4)
  );

  pipeline_hazard_ctrl #(.MUL_LAT(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .forward_en(forward_en), .src1_ID(src1_ID), .src2_ID(src2_ID),
    .two_src_ID(two_src_ID), .dest_EXE(dest_EXE), .WB_EN_EXE(WB_EN_EXE),
    .MEM_R_EN_EXE(MEM_R_EN_EXE), .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM),
    .branch_taken_EXE(branch_taken_EXE), .mul_start_EXE(mul_start_EXE),
    .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .stall_IF(sif1), .stall_ID(sid1), .bubble_EXE(bub1), .flush_IF_ID(fl1),
    .freeze(frz1), .mul_done(done1), .stall_cycles(cnt1)
  );

  // Any read of a register that an unforwardable producer is about to write.
  function automatic bit ref_hazard(input in_t v);
    bit reads[32];
    foreach (reads[i]) reads[i] = 1'b0;
    reads[v.s1] = 1'b1;
    if (v.two) reads[v.s2] = 1'b1;
    reads[0] = 1'b0;
    if (v.fwd) return v.wbe && v.lde && reads[v.de];
    return (v.wbe && reads[v.de]) || (v.wbm && reads[v.dm]);
  endfunction

  function automatic out_t model_out(input int k, input in_t v);
    out_t o;
    bit   flow;
    o    = O_NONE;
    flow = 1'b0;
    if (m_memwait[k]) begin
      if (!v.mrdy) o = O_FRZ; else flow = 1'b1;
    end else if (m_mul_left[k] > 0) begin
      if (m_mul_left[k] > 1) o = O_FRZ;
      else begin o.done = 1'b1; flow = 1'b1; end
    end else if (v.mreq && !v.mrdy) begin
      o = O_FRZ;
    end else if (v.mul && lat[k] > 1) begin
      o = O_FRZ;
    end else begin
      o.done = v.mul;
      flow   = 1'b1;
    end
    if (flow) begin
      if (v.br) begin o.fl = 1'b1; o.bub = 1'b1; end
      else if (ref_hazard(v)) begin o.sif = 1'b1; o.sid = 1'b1; o.bub = 1'b1; end
    end
    return o;
  endfunction

  task automatic model_update(input int k, input in_t v, input out_t o);
    if (m_memwait[k])                  m_memwait[k]  = !v.mrdy;
    else if (m_mul_left[k] > 0)        m_mul_left[k] = m_mul_left[k] - 1;
    else if (v.mreq && !v.mrdy)        m_memwait[k]  = 1'b1;
    else if (v.mul && lat[k] > 1)      m_mul_left[k] = int'(lat[k]) - 1;
    if (v.clr)                             m_cnt[k] = 0;
    else if (o.sif && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_memwait[k]  = 1'b0;
      m_mul_left[k] = 0;
      m_cnt[k]      = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    forward_en = v.fwd;  src1_ID = v.s1;  src2_ID = v.s2;  two_src_ID = v.two;
    dest_EXE = v.de;  WB_EN_EXE = v.wbe;  MEM_R_EN_EXE = v.lde;
    dest_MEM = v.dm;  WB_EN_MEM = v.wbm;  branch_taken_EXE = v.br;
    mul_start_EXE = v.mul;  mem_req_MEM = v.mreq;  mem_ready = v.mrdy;  perf_clr = v.clr;
  endtask

  function automatic out_t get4();
    return {sif4, sid4, bub4, fl4, frz4, done4};
  endfunction

  function automatic out_t get1();
    return {sif1, sid1, bub1, fl1, frz1, done1};
  endfunction

  function automatic in_t mk(input bit fwd, input int s1, input int s2, input bit two,
                             input int de, input bit wbe, input bit lde,
                             input int dm, input bit wbm, input bit br);
    in_t v;
    v      = '0;
    v.fwd  = fwd;  v.s1 = 5'(s1);  v.s2 = 5'(s2);  v.two = two;
    v.de   = 5'(de);  v.wbe = wbe;  v.lde = lde;
    v.dm   = 5'(dm);  v.wbm = wbm;  v.br = br;
    return v;
  endfunction

  // mode 0: both instances vs model; 1: lat-4 instance vs x4; 2: both vs constants.
  task automatic tick(input in_t v, input string nm, input int mode, input out_t x4, input out_t x1);
    out_t e4, e1;
    drive(v);
    @(negedge clk);
    e4     = model_out(0, v);
    e1     = model_out(1, v);
    s_cnt4 = 64'(cnt4);
    s_cnt1 = 64'(cnt1);
    if (mode == 0) begin
      chk({nm, "/l4"}, 64'(get4()), 64'(e4));
      chk({nm, "/l1"}, 64'(get1()), 64'(e1));
    end else begin
      chk({nm, "/l4"}, 64'(get4()), 64'(x4));
      if (mode == 2) chk({nm, "/l1"}, 64'(get1()), 64'(x1));
    end
    chk({nm, "/cnt4"}, s_cnt4, m_cnt[0]);
    chk({nm, "/cnt1"}, s_cnt1, m_cnt[1]);
    @(posedge clk);
    model_update(0, v, e4);
    model_update(1, v, e1);
    #1;
  endtask

  function automatic in_t rnd_in();
    in_t v;
    v.fwd  = 1'($urandom_range(0, 1));
    v.s1   = 5'($urandom_range(0, 3));
    v.s2   = 5'($urandom_range(0, 3));
    v.two  = 1'($urandom_range(0, 1));
    v.de   = 5'($urandom_range(0, 3));
    v.wbe  = 1'($urandom_range(0, 1));
    v.lde  = 1'($urandom_range(0, 1));
    v.dm   = 5'($urandom_range(0, 3));
    v.wbm  = 1'($urandom_range(0, 1));
    v.br   = ($urandom_range(0, 5) == 0);
    v.mul  = ($urandom_range(0, 5) == 0);
    v.mreq = ($urandom_range(0, 3) == 0);
    v.mrdy = 1'($urandom_range(0, 1));
    v.clr  = ($urandom_range(0, 31) == 0);
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    in_t  idle, lu, v;
    longint unsigned base4;

    idle = '0;
    lu   = mk(1, 5, 0, 0, 5, 1, 1, 0, 0, 0);

    tbl.push_back('{"load_use",      lu,                                  O_STALL});
    tbl.push_back('{"load_r0",       mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0),    O_NONE});
    tbl.push_back('{"fwd_alu",       mk(1, 5, 0, 0, 5, 1, 0, 0, 0, 0),    O_NONE});
    tbl.push_back('{"load_src2",     mk(1, 0, 6, 1, 6, 1, 1, 0, 0, 0),    O_STALL});
    tbl.push_back('{"load_src2_one", mk(1, 0, 6, 0, 6, 1, 1, 0, 0, 0),    O_NONE});
    tbl.push_back('{"nofwd_mem",     mk(0, 0, 7, 1, 0, 0, 0, 7, 1, 0),    O_STALL});
    tbl.push_back('{"nofwd_mem_one", mk(0, 0, 7, 0, 0, 0, 0, 7, 1, 0),    O_NONE});
    tbl.push_back('{"nofwd_exe",     mk(0, 3, 0, 0, 3, 1, 0, 0, 0, 0),    O_STALL});
    tbl.push_back('{"nofwd_exe_nwb", mk(0, 3, 0, 0, 3, 0, 0, 0, 0, 0),    O_NONE});
    tbl.push_back('{"fwd_mem_only",  mk(1, 7, 0, 0, 0, 0, 0, 7, 1, 0),    O_NONE});
    tbl.push_back('{"branch_hz",     mk(1, 5, 0, 0, 5, 1, 1, 0, 0, 1),    O_FLUSH});
    tbl.push_back('{"branch",        mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1),    O_FLUSH});
    tbl.push_back('{"idle",          idle,                                O_NONE});

    // Reset: outputs gated even with a live hazard on the inputs.
    rst = 1'b1;
    model_reset();
    drive(lu);
    #2;
    chk("rst_out4", 64'(get4()), 64'(O_NONE));
    chk("rst_out1", 64'(get1()), 64'(O_NONE));
    chk("rst_cnt4", 64'(cnt4), 64'd0);
    drive(idle);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) tick(tbl[i].v, tbl[i].nm, 2, tbl[i].o, tbl[i].o);

    // Memory wait: 3 frozen cycles, released on the ready cycle.
    base4 = m_cnt[0];
    v = idle; v.mreq = 1'b1;
    for (int i = 0; i < 3; i++) tick(v, "memwait", 2, O_FRZ, O_FRZ);
    v.mrdy = 1'b1;
    tick(v, "mem_ready", 2, O_NONE, O_NONE);
    tick(idle, "mem_after", 2, O_NONE, O_NONE);
    chk("memwait_cnt", s_cnt4, base4 + 3);

    // Multiply held high: no retrigger on the done cycle; latency-1 pulses immediately.
    v = idle; v.mul = 1'b1;
    tick(v, "mul_t0", 2, O_FRZ, O_DONE);
    tick(v, "mul_t1", 2, O_FRZ, O_DONE);
    tick(v, "mul_t2", 2, O_FRZ, O_DONE);
    tick(v, "mul_t3", 2, O_DONE, O_DONE);
    tick(idle, "mul_t4", 2, O_NONE, O_NONE);

    // Multiply completion with a branch in the same cycle.
    tick(v, "mulbr_t0", 1, O_FRZ, O_NONE);
    tick(idle, "mulbr_t1", 1, O_FRZ, O_NONE);
    tick(idle, "mulbr_t2", 1, O_FRZ, O_NONE);
    tick(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "mulbr_t3", 1, 6'b001101, O_NONE);

    // Long memory wait drives the 3-bit counter into saturation.
    v = idle; v.mreq = 1'b1;
    for (int i = 0; i < 10; i++) tick(v, "sat_wait", 2, O_FRZ, O_FRZ);
    v.mrdy = 1'b1;
    tick(v, "sat_ready", 2, O_NONE, O_NONE);
    tick(idle, "sat_after", 2, O_NONE, O_NONE);
    chk("sat_cnt1", s_cnt1, 64'd7);

    // Clear wins over a same-cycle increment.
    v = lu; v.clr = 1'b1;
    tick(v, "clr_stall", 2, O_STALL, O_STALL);
    tick(idle, "clr_after", 2, O_NONE, O_NONE);
    chk("clr_cnt4", s_cnt4, 64'd0);
    chk("clr_cnt1", s_cnt1, 64'd0);

    // Asynchronous reset between edges while the multiply is in progress.
    v = idle; v.mul = 1'b1;
    tick(v, "ar_start", 1, O_FRZ, O_NONE);
    tick(idle, "ar_busy", 1, O_FRZ, O_NONE);
    drive(idle);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out4", 64'(get4()), 64'(O_NONE));
    chk("ar_cnt4", 64'(cnt4), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tick(idle, "ar_run", 2, O_NONE, O_NONE);
    tick(idle, "ar_run2", 2, O_NONE, O_NONE);
    tick(lu, "ar_hz", 2, O_STALL, O_STALL);

    for (int i = 0; i < 400; i++) tick(rnd_in(), "rnd", 0, O_NONE, O_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/freeze sequencer for the 5-stage MIPS pipeline. It sits beside the EXE-stage forwarding unit and decides when PC, IF/ID and ID/EXE hold, bubble or flush. It detects load-use and RAW hazards, handles taken-branch flush, and sequences two multi-cycle events: data-memory wait (mem_ready handshake) and a multi-cycle multiply in EXE. It also keeps a saturating stall-cycle performance counter.

Parameters:
MUL_LAT, 4, multiply latency in cycles (>=1); pipeline freezes for MUL_LAT-1 cycles.
CNT_W, 32, width of stall_cycles counter.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
forward_en  in  1  1 = forwarding unit active (stall only on load-use)
src1_ID  in  5  ID-stage source register 1
src2_ID  in  5  ID-stage source register 2
two_src_ID  in  1  ID instruction reads src2_ID
dest_EXE  in  5  EXE-stage destination register
WB_EN_EXE  in  1  EXE instruction writes back
MEM_R_EN_EXE  in  1  EXE instruction is a load
dest_MEM  in  5  MEM-stage destination register
WB_EN_MEM  in  1  MEM instruction writes back
branch_taken_EXE  in  1  branch resolved taken in EXE
mul_start_EXE  in  1  multi-cycle multiply is in EXE
mem_req_MEM  in  1  MEM stage is accessing data memory
mem_ready  in  1  data memory access completes this cycle
perf_clr  in  1  synchronous clear of stall_cycles
stall_IF  out  1  hold PC
stall_ID  out  1  hold IF/ID register
bubble_EXE  out  1  load NOP into ID/EXE
flush_IF_ID  out  1  load NOP into IF/ID
freeze  out  1  hold ID/EXE, EXE/MEM, MEM/WB
mul_done  out  1  one-cycle pulse: multiply result valid, EXE advances
stall_cycles  out  CNT_W  count of cycles with stall_IF=1, saturating

Behaviour:
- Registers: state {RUN, MEM_WAIT, MUL_BUSY}, mul_cnt (width ceil(log2(MUL_LAT))+1), stall_cycles. Reset: state=RUN, mul_cnt=0, stall_cycles=0, applied immediately on rst rising. All control outputs are 0 while rst=1.
- Outputs are combinational from state, mul_cnt and inputs, with the same-cycle effect. State and counters update on the clk rising edge.
- Hazard: register 0 never matches. With forward_en=1: hazard = WB_EN_EXE & MEM_R_EN_EXE & dest_EXE!=0 & (src1_ID==dest_EXE | two_src_ID & src2_ID==dest_EXE). With forward_en=0: hazard = the same compare on EXE (without the load term) OR the same compare against dest_MEM/WB_EN_MEM.
- RUN priority, highest first:
  1. mem_req_MEM & !mem_ready: freeze=stall_IF=stall_ID=1, bubble=flush=0; next state MEM_WAIT.
  2. mul_start_EXE & MUL_LAT>1: same freeze outputs; mul_cnt<=MUL_LAT-2; next state MUL_BUSY.
  3. branch_taken_EXE: flush_IF_ID=1, bubble_EXE=1, stalls=0. Branch overrides hazard.
  4. hazard: stall_IF=stall_ID=1, bubble_EXE=1.
  5. otherwise all 0.
- When MUL_LAT=1: mul_start is ignored (no freeze) and mul_done is asserted in that cycle.
- MEM_WAIT: freeze=stall_IF=stall_ID=!mem_ready. On mem_ready, go to RUN, and in that same cycle evaluate priorities 3–5 only.
- MUL_BUSY:
  - mul_cnt!=0: freeze outputs, mul_cnt decrements.
  - mul_cnt==0: freeze=0, mul_done=1, go to RUN, evaluate priorities 3–5. mul_start_EXE still high is not a retrigger.
- Total freeze for a multiply = MUL_LAT-1 cycles, counted from the RUN cycle that sees mul_start.
- Memory request during MUL_BUSY: impossible, because MEM is frozen. A multiply blocked behind MEM_WAIT is seen again in RUN after release.
- stall_cycles:
  - Increments on each edge with stall_IF=1.
  - Holds at all-ones.
  - perf_clr has priority over increment (value becomes 0).
- Reset mid-operation (in MEM_WAIT or MUL_BUSY): return to RUN, abandon mul_cnt, no mul_done pulse.

Decomposition:
- Package hazard_pkg: state enum (RUN=2'd0, MEM_WAIT=2'd1, MUL_BUSY=2'd2), REG_ZERO=5'd0, REG_AW=5.
- One sub-module: raw_hazard_detect (combinational). Inputs: src1/src2/two_src, dest/wb_en/is_load, forward_en. Output: hazard. Instantiated once, with the MEM compare built internally.

Test Plan:
- Load-use: forward_en=1, EXE load dest=5, WB_EN_EXE=1, ID src1=5 -> stall_IF=stall_ID=bubble_EXE=1 for one cycle; same with dest=0 -> no stall.
- No-forward RAW: forward_en=0, MEM dest=7 WB_EN_MEM=1, ID src2=7, two_src=1 -> stall; two_src=0 -> no stall.
- Branch + hazard in the same cycle -> flush_IF_ID=1, bubble_EXE=1, stall_IF=0.
- Memory wait: mem_req_MEM=1, mem_ready low for 3 cycles then high -> freeze=1 for exactly 3 cycles, 0 on the ready cycle; stall_cycles +3.
- Multiply: MUL_LAT=4, mul_start at T -> freeze T..T+2, mul_done at T+3 only; with MUL_LAT=1 -> no freeze, mul_done at T.
- Async rst asserted mid-MUL_BUSY between edges -> outputs 0 immediately, stall_cycles=0, RUN after release, no mul_done; perf_clr with stall_IF=1 -> counter 0.
